counter_step_decoder: RTL and testbench

- Observes the output of an up/down/load counter and recovers the command sequence that produced it: hold, count up, count down, or jump (load or reset).
- Sits on the monitor side of the counter as a checker/telemetry block. It samples the count, classifies each sample-to-sample transition and keeps saturating event statistics.
- It is the decoding end of the counter's command encoding.

---
 rtl/counter_step_decoder_pkg.sv | 23 ++
 rtl/counter_step_decoder_if.sv | 36 +++
 rtl/counter_step_decoder_sat_counter.sv | 30 +++
 rtl/counter_step_decoder.sv | 102 ++++++++++
 tb/tb_counter_step_decoder.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/counter_step_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_step_decoder_pkg
// Description : Shared step codes and state encodings for the counter step
//               decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_step_decoder_pkg;

    typedef logic [1:0] step_code_t;

    // Step classification codes
    localparam step_code_t STEP_HOLD = 2'b00;
    localparam step_code_t STEP_UP   = 2'b01;
    localparam step_code_t STEP_DOWN = 2'b10;
    localparam step_code_t STEP_JUMP = 2'b11;

    // Decoder states: no reference sample yet / reference sample held
    localparam logic [0:0] ST_EMPTY  = 1'b0;
    localparam logic [0:0] ST_PRIMED = 1'b1;

endpackage : counter_step_decoder_pkg
`default_nettype wire

// File: rtl/counter_step_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_step_decoder_if
// Description : Sample/telemetry bundle between the counter monitor source
//               (master) and the step decoder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface counter_step_decoder_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             sample_en;
    logic [WIDTH-1:0] count_in;
    logic             clear_stats;
    logic             step_valid;
    logic [1:0]       step_code;
    logic             wrap;
    logic [WIDTH-1:0] jump_value;
    logic [CNT_W-1:0] run_len;
    logic [CNT_W-1:0] up_events;
    logic [CNT_W-1:0] down_events;
    logic [CNT_W-1:0] jump_events;

    modport master (
        output sample_en, count_in, clear_stats,
        input  step_valid, step_code, wrap, jump_value, run_len,
               up_events, down_events, jump_events
    );

    modport slave (
        input  sample_en, count_in, clear_stats,
        output step_valid, step_code, wrap, jump_value, run_len,
               up_events, down_events, jump_events
    );
endinterface : counter_step_decoder_if
`default_nettype wire

// File: rtl/counter_step_decoder_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating event counter with clear; clear together with an
//               increment lands on 1 so the clearing cycle's event is kept.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         clr,
    input  wire logic         inc,
    output logic      [W-1:0] q
);

    // Clear wins over increment; increment stops at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= inc ? W'(1) : '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule : sat_counter
`default_nettype wire

// File: rtl/counter_step_decoder.sv
`default_nettype none
// ============================================================================
// Module      : counter_step_decoder
// Description : Recovers hold/up/down/jump commands from successive samples
//               of an up/down/load counter and keeps saturating statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_step_decoder
    import counter_step_decoder_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input wire logic               clk,
    input wire logic               rst,
    counter_step_decoder_if.slave  bus
);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_prev;
    step_code_t       w_code;
    logic             w_wrap;
    logic             w_classify;

    assign w_classify = bus.sample_en && (r_state == ST_PRIMED);

    // Classify the new sample against the reference, modulo 2^WIDTH
    always_comb begin
        w_code = STEP_JUMP;
        w_wrap = 1'b0;
        if (bus.count_in == r_prev) begin
            w_code = STEP_HOLD;
        end else if (bus.count_in == (r_prev + WIDTH'(1))) begin
            w_code = STEP_UP;
            w_wrap = (r_prev == '1);
        end else if (bus.count_in == (r_prev - WIDTH'(1))) begin
            w_code = STEP_DOWN;
            w_wrap = (r_prev == '0);
        end
    end

    // Reference sample, state and registered classification outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_EMPTY;
            r_prev         <= '0;
            bus.step_valid <= 1'b0;
            bus.step_code  <= STEP_HOLD;
            bus.wrap       <= 1'b0;
            bus.jump_value <= '0;
            bus.run_len    <= '0;
        end else begin
            bus.step_valid <= 1'b0;
            if (bus.sample_en) begin
                r_prev <= bus.count_in;
                if (r_state == ST_EMPTY) begin
                    r_state <= ST_PRIMED;
                end else begin
                    bus.step_valid <= 1'b1;
                    bus.step_code  <= w_code;
                    bus.wrap       <= w_wrap;
                    if (w_code == STEP_JUMP) begin
                        bus.jump_value <= bus.count_in;
                        bus.run_len    <= '0;
                    end else if (w_code == bus.step_code) begin
                        if (bus.run_len != '1) begin
                            bus.run_len <= bus.run_len + CNT_W'(1);
                        end
                    end else begin
                        bus.run_len <= CNT_W'(1);
                    end
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_up_events (
        .clk (clk),
        .rst (rst),
        .clr (bus.clear_stats),
        .inc (w_classify && (w_code == STEP_UP)),
        .q   (bus.up_events)
    );

    sat_counter #(.W(CNT_W)) u_down_events (
        .clk (clk),
        .rst (rst),
        .clr (bus.clear_stats),
        .inc (w_classify && (w_code == STEP_DOWN)),
        .q   (bus.down_events)
    );

    sat_counter #(.W(CNT_W)) u_jump_events (
        .clk (clk),
        .rst (rst),
        .clr (bus.clear_stats),
        .inc (w_classify && (w_code == STEP_JUMP)),
        .q   (bus.jump_events)
    );

endmodule : counter_step_decoder
`default_nettype wire

// File: tb/tb_counter_step_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_step_decoder
// Description : Self-checking bench for counter_step_decoder. Two instances
//               (8-bit and 4-bit statistics) see identical stimulus and are
//               compared every cycle with a difference-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_step_decoder;

    logic clk;
    logic rst;

    counter_step_decoder_if #(.WIDTH(4), .CNT_W(8)) bus_a ();
    counter_step_decoder_if #(.WIDTH(4), .CNT_W(4)) bus_b ();

    counter_step_decoder #(.WIDTH(4), .CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    counter_step_decoder #(.WIDTH(4), .CNT_W(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state; index 0 = 8-bit stats, index 1 = 4-bit stats
    int m_primed, m_prev, m_valid, m_code, m_wrap, m_jv;
    int m_run[2], m_up[2], m_dn[2], m_jp[2];
    int mx[2] = '{255, 15};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v, input int m);
        return (v >= m) ? m : v + 1;
    endfunction

    task automatic model_reset();
        m_primed = 0; m_prev = 0; m_valid = 0; m_code = 0; m_wrap = 0; m_jv = 0;
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_up[k] = 0; m_dn[k] = 0; m_jp[k] = 0;
        end
    endtask

    task automatic model_step(input bit r, input bit en, input int v, input bit clr);
        int diff, code;
        if (r) begin
            model_reset();
            return;
        end
        m_valid = 0;
        if (clr) begin
            for (int k = 0; k < 2; k++) begin
                m_up[k] = 0; m_dn[k] = 0; m_jp[k] = 0;
            end
        end
        if (!en) return;
        if (m_primed == 0) begin
            m_primed = 1;
            m_prev   = v;
            return;
        end
        diff = (v - m_prev) & 15;
        code = (diff == 0) ? 0 : (diff == 1) ? 1 : (diff == 15) ? 2 : 3;
        for (int k = 0; k < 2; k++) begin
            if (code == 3)           m_run[k] = 0;
            else if (code == m_code) m_run[k] = sat_inc(m_run[k], mx[k]);
            else                     m_run[k] = 1;
            if (code == 1) m_up[k] = sat_inc(m_up[k], mx[k]);
            if (code == 2) m_dn[k] = sat_inc(m_dn[k], mx[k]);
            if (code == 3) m_jp[k] = sat_inc(m_jp[k], mx[k]);
        end
        m_wrap  = ((code == 1) && (v == 0)) || ((code == 2) && (v == 15)) ? 1 : 0;
        if (code == 3) m_jv = v;
        m_code  = code;
        m_valid = 1;
        m_prev  = v;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(bus_a.step_valid), 32'(m_valid));
        chk({tag, ".code"},  32'(bus_a.step_code),  32'(m_code));
        chk({tag, ".wrap"},  32'(bus_a.wrap),       32'(m_wrap));
        chk({tag, ".jval"},  32'(bus_a.jump_value), 32'(m_jv));
        chk({tag, ".run8"},  32'(bus_a.run_len),    32'(m_run[0]));
        chk({tag, ".up8"},   32'(bus_a.up_events),  32'(m_up[0]));
        chk({tag, ".dn8"},   32'(bus_a.down_events),32'(m_dn[0]));
        chk({tag, ".jp8"},   32'(bus_a.jump_events),32'(m_jp[0]));
        chk({tag, ".valid4"},32'(bus_b.step_valid), 32'(m_valid));
        chk({tag, ".run4"},  32'(bus_b.run_len),    32'(m_run[1]));
        chk({tag, ".up4"},   32'(bus_b.up_events),  32'(m_up[1]));
        chk({tag, ".dn4"},   32'(bus_b.down_events),32'(m_dn[1]));
        chk({tag, ".jp4"},   32'(bus_b.jump_events),32'(m_jp[1]));
    endtask

    // One clock: drive at negedge, advance the model at the edge, check #1 later
    task automatic cyc(input string tag, input bit r, input bit en, input int v, input bit clr);
        @(negedge clk);
        rst               = r;
        bus_a.sample_en   = en;
        bus_b.sample_en   = en;
        bus_a.count_in    = 4'(v);
        bus_b.count_in    = 4'(v);
        bus_a.clear_stats = clr;
        bus_b.clear_stats = clr;
        @(posedge clk);
        model_step(r, en, v, clr);
        #1;
        check_all(tag);
    endtask

    initial begin
        int v, sel;
        rst = 1'b1;
        bus_a.sample_en = 1'b0; bus_b.sample_en = 1'b0;
        bus_a.count_in = '0;    bus_b.count_in = '0;
        bus_a.clear_stats = 1'b0; bus_b.clear_stats = 1'b0;
        model_reset();

        // Reset and prime
        cyc("rst0", 1, 0, 0, 0);
        cyc("rst1", 1, 1, 9, 0);
        cyc("prime", 0, 1, 0, 0);

        // Up sweep 1..15 then wrap to 0
        for (int i = 1; i <= 16; i++) cyc("upsweep", 0, 1, i & 15, 0);
        chk("upsweep.up_events", 32'(bus_a.up_events), 32'd16);
        chk("upsweep.run_len",   32'(bus_a.run_len),   32'd16);
        chk("upsweep.wrap_last", 32'(bus_a.wrap),      32'd1);

        // Climb to 2, then down through the boundary
        cyc("to1", 0, 1, 1, 0);
        cyc("to2", 0, 1, 2, 0);
        cyc("dn1", 0, 1, 1, 0);
        chk("dn1.run_restart", 32'(bus_a.run_len), 32'd1);
        cyc("dn0", 0, 1, 0, 0);
        cyc("dn15", 0, 1, 15, 0);
        chk("dn15.wrap", 32'(bus_a.wrap), 32'd1);

        // Jumps and a hold afterwards
        cyc("jmp7", 0, 1, 7, 0);
        cyc("jmp3", 0, 1, 3, 0);
        chk("jmp3.jump_value", 32'(bus_a.jump_value), 32'd3);
        cyc("hold3", 0, 1, 3, 0);
        chk("hold3.run_len", 32'(bus_a.run_len), 32'd1);

        // Sampling gap: outputs hold, no pulse
        for (int i = 0; i < 5; i++) cyc("gap", 0, 0, $urandom_range(0, 15), 0);

        // Clear together with an UP sample
        cyc("clr_up", 0, 1, 4, 1);
        chk("clr_up.up_events", 32'(bus_a.up_events), 32'd1);
        cyc("clr_only", 0, 0, 0, 1);

        // Saturation of the 4-bit statistics
        for (int i = 1; i <= 20; i++) cyc("sat", 0, 1, (4 + i) & 15, 0);
        chk("sat.up4",  32'(bus_b.up_events), 32'd15);
        chk("sat.run4", 32'(bus_b.run_len),   32'd15);

        // Randomized traffic biased toward hold/up/down steps
        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       v = m_prev;
                1:       v = (m_prev + 1) & 15;
                2:       v = (m_prev - 1) & 15;
                default: v = int'($urandom_range(0, 15));
            endcase
            cyc("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 4) != 0),
                v, ($urandom_range(0, 29) == 0));
        end

        // Mid-stream reset: outputs clear, next sample only re-primes
        cyc("pre_rst", 0, 1, 5, 0);
        cyc("pre_rst2", 0, 1, 6, 0);
        cyc("mid_rst", 1, 1, 7, 0);
        chk("mid_rst.up_events", 32'(bus_a.up_events), 32'd0);
        cyc("reprime", 0, 1, 8, 0);
        chk("reprime.valid", 32'(bus_a.step_valid), 32'd0);
        cyc("after", 0, 1, 9, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_counter_step_decoder
`default_nettype wire
